// File: rtl/ddr2_axi_traffic_chk_if.sv
// AXI bus between the traffic checker (master) and the ddr2_ctrl slave port.
// Carries the AW, W, B, AR and R channels without ids or response codes.
interface ddr2_axi_traffic_chk_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  wvalid;
  logic                  wready;
  logic                  wlast;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  bvalid;
  logic                  bready;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  rvalid;
  logic                  rready;
  logic                  rlast;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, awlen, input awready,
    output wvalid, wlast, wdata, input wready,
    input bvalid, output bready,
    output arvalid, araddr, arlen, input arready,
    input rvalid, rlast, rdata, output rready
  );

  modport slave (
    input awvalid, awaddr, awlen, output awready,
    input wvalid, wlast, wdata, output wready,
    output bvalid, input bready,
    input arvalid, araddr, arlen, output arready,
    output rvalid, rlast, rdata, input rready
  );
endinterface

// File: rtl/ddr2_axi_traffic_chk.sv
// Self-checking AXI traffic engine: writes an address window with a
// generated pattern, reads it back and compares beat by beat.
// Optional feature macro TRAFFIC_CHK_LOOP_EN adds continuous looping
// (input loop, output iter_cnt) with the LFSR carried across iterations.
module ddr2_axi_traffic_chk #(
  parameter int          ADDR_WIDTH = 26,
  parameter int          DATA_WIDTH = 32,
  parameter int          BURST_LEN  = 128,
  parameter int          ADDR_STEP  = 2,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] begin_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
`ifdef TRAFFIC_CHK_LOOP_EN
  input  logic                  loop,
  output logic [15:0]           iter_cnt,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  ddr2_axi_traffic_chk_if.master axi
);

  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [8:0]            MAX_LEN   = 9'(BURST_LEN);
  localparam logic [31:0]           LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, FIN} state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] w_rem, r_rem, w_addr, r_addr;
  logic [8:0]            len_q, beat_q;
  logic [31:0]           wg_k, rg_k, wg_lfsr, rg_lfsr;
  logic [ADDR_WIDTH-1:0] wg_addr, rg_addr;
  logic [ADDR_WIDTH-1:0] span, words_calc;
  logic                  last_beat, beat_bad;
  logic [DATA_WIDTH-1:0] exp_rdata;
`ifdef TRAFFIC_CHK_LOOP_EN
  logic [ADDR_WIDTH-1:0] base_q, words_q;
`endif

  // Beats in the next burst: the configured maximum or whatever is left.
  function automatic logic [8:0] burst_of(input logic [ADDR_WIDTH-1:0] rem);
    if (rem >= ADDR_WIDTH'(BURST_LEN)) return MAX_LEN;
    return 9'(rem);
  endfunction

  // Galois LFSR, taps 32,22,2,1, shifting right.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m, input logic [31:0] k,
                                                    input logic [31:0] lfsr,
                                                    input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    case (m)
      2'd0:    d = DATA_WIDTH'(k);
      2'd1:    for (int i = 0; i < DATA_WIDTH; i++) d[i] = lfsr[5'(i % 32)];
      2'd2:    d = DATA_WIDTH'(1) << (k % DATA_WIDTH);
      default: d = DATA_WIDTH'(addr);
    endcase
    return d;
  endfunction

  assign span       = end_addr - begin_addr;
  assign words_calc = (end_addr > begin_addr) ? (span / STEP) : '0;
  assign last_beat  = (beat_q == len_q - 9'd1);
  assign exp_rdata  = pattern(mode_q, rg_k, rg_lfsr, rg_addr);
  assign beat_bad   = (axi.rdata != exp_rdata) || (axi.rlast != last_beat);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and AXI channel outputs; payloads are zero outside their state.
  always_comb begin
    state_d     = state_q;
    axi.awvalid = 1'b0;
    axi.awaddr  = '0;
    axi.awlen   = '0;
    axi.wvalid  = 1'b0;
    axi.wlast   = 1'b0;
    axi.wdata   = '0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.araddr  = '0;
    axi.arlen   = '0;
    axi.rready  = 1'b0;
    case (state_q)
      IDLE: if (start && init_end) state_d = (words_calc != '0) ? AW : FIN;
      AW: begin
        axi.awvalid = 1'b1;
        axi.awaddr  = w_addr;
        axi.awlen   = 8'(burst_of(w_rem) - 9'd1);
        if (axi.awready) state_d = W;
      end
      W: begin
        axi.wvalid = 1'b1;
        axi.wlast  = last_beat;
        axi.wdata  = pattern(mode_q, wg_k, wg_lfsr, wg_addr);
        if (axi.wready && last_beat) state_d = B;
      end
      B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_d = (w_rem != '0) ? AW : AR;
      end
      AR: begin
        axi.arvalid = 1'b1;
        axi.araddr  = r_addr;
        axi.arlen   = 8'(burst_of(r_rem) - 9'd1);
        if (axi.arready) state_d = R;
      end
      R: begin
        axi.rready = 1'b1;
        if (axi.rvalid && last_beat) state_d = (r_rem != '0) ? AR : FIN;
      end
      FIN: begin
        state_d = IDLE;
`ifdef TRAFFIC_CHK_LOOP_EN
        if (loop) state_d = (words_q != '0) ? AW : FIN;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Run configuration, burst bookkeeping, pattern generators and result status.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0; done <= 1'b0; pass <= 1'b0;
      err_cnt <= '0; first_err_addr <= '0; mode_q <= '0;
      w_rem <= '0; r_rem <= '0; w_addr <= '0; r_addr <= '0;
      len_q <= '0; beat_q <= '0;
      wg_k <= '0; rg_k <= '0; wg_lfsr <= '0; rg_lfsr <= '0;
      wg_addr <= '0; rg_addr <= '0;
`ifdef TRAFFIC_CHK_LOOP_EN
      iter_cnt <= '0; base_q <= '0; words_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start && init_end) begin
          busy <= 1'b1; pass <= 1'b0; err_cnt <= '0; first_err_addr <= '0;
          mode_q <= mode;
          w_rem <= words_calc; r_rem <= words_calc;
          w_addr <= begin_addr; r_addr <= begin_addr;
          wg_k <= '0; rg_k <= '0; wg_lfsr <= LFSR_SEED; rg_lfsr <= LFSR_SEED;
          wg_addr <= begin_addr; rg_addr <= begin_addr; beat_q <= '0;
`ifdef TRAFFIC_CHK_LOOP_EN
          iter_cnt <= '0; base_q <= begin_addr; words_q <= words_calc;
`endif
        end
        AW: if (axi.awready) begin
          len_q  <= burst_of(w_rem);
          w_rem  <= w_rem - ADDR_WIDTH'(burst_of(w_rem));
          w_addr <= w_addr + ADDR_WIDTH'(burst_of(w_rem)) * STEP;
          beat_q <= '0;
        end
        W: if (axi.wready) begin
          beat_q  <= last_beat ? 9'd0 : beat_q + 9'd1;
          wg_k    <= wg_k + 32'd1;
          wg_lfsr <= lfsr_next(wg_lfsr);
          wg_addr <= wg_addr + STEP;
        end
        AR: if (axi.arready) begin
          len_q  <= burst_of(r_rem);
          r_rem  <= r_rem - ADDR_WIDTH'(burst_of(r_rem));
          r_addr <= r_addr + ADDR_WIDTH'(burst_of(r_rem)) * STEP;
          beat_q <= '0;
        end
        R: if (axi.rvalid) begin
          beat_q  <= last_beat ? 9'd0 : beat_q + 9'd1;
          rg_k    <= rg_k + 32'd1;
          rg_lfsr <= lfsr_next(rg_lfsr);
          rg_addr <= rg_addr + STEP;
          if (beat_bad) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (err_cnt == 16'd0) first_err_addr <= rg_addr;
          end
        end
        FIN: begin
          done <= 1'b1;
          pass <= (err_cnt == 16'd0);
`ifdef TRAFFIC_CHK_LOOP_EN
          if (iter_cnt != 16'hFFFF) iter_cnt <= iter_cnt + 16'd1;
          if (loop) begin
            w_rem <= words_q; r_rem <= words_q;
            w_addr <= base_q; r_addr <= base_q;
            wg_k <= '0; rg_k <= '0; wg_lfsr <= rg_lfsr;
            wg_addr <= base_q; rg_addr <= base_q; beat_q <= '0;
          end else begin
            busy <= 1'b0;
          end
`else
          busy <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ddr2_axi_traffic_chk.md
Name: ddr2_axi_traffic_chk

Overview:
- Parametrised, self-checking AXI traffic engine; successor to the fixed write-then-read stimulus pair that drives `ddr2_ctrl` in simulation.
- Writes a programmable address window in AXI bursts of configurable length, reads the window back, regenerates the expected pattern and compares beat by beat.
- Reports pass/fail, error count and the first failing address.
- Sits between test control (or on-board debug logic) and the `ddr2_ctrl` AXI slave port.

Parameters:
- ADDR_WIDTH, 26, AXI address width (ROW 13 + COL 10 + BA 3).
- DATA_WIDTH, 32, AXI data width (2 x DQ for DDR2 x16).
- BURST_LEN, 128, maximum beats per AXI burst; legal range 1..256.
- ADDR_STEP, 2, address increment per data beat (column units per beat).
- LFSR_SEED, 32'hACE1_0001, non-zero seed for pattern mode 1.

Ports:
- clk  in  1  system clock, shared with `ddr2_ctrl`.
- rst  in  1  synchronous active-high reset.
- init_end  in  1  DDR2 initialisation complete; start is ignored while low.
- start  in  1  single-cycle run request.
- mode  in  2  pattern: 0 incrementing, 1 LFSR, 2 walking-one, 3 address-as-data.
- begin_addr  in  ADDR_WIDTH  first address (inclusive).
- end_addr  in  ADDR_WIDTH  last address (exclusive).
- busy  out  1  run in progress.
- done  out  1  single-cycle pulse at the end of a run.
- pass  out  1  last run completed with err_cnt == 0; held until the next start.
- err_cnt  out  16  mismatching beats, saturating at 16'hFFFF.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch.
- axi_awvalid/awready/awaddr[ADDR_WIDTH]/awlen[8]: AW channel (awvalid, awaddr, awlen out; awready in).
- axi_wvalid/wready/wlast/wdata[DATA_WIDTH]: W channel (wvalid, wlast, wdata out; wready in).
- axi_bvalid in, axi_bready out: B channel.
- axi_arvalid/arready/araddr/arlen: AR channel (arvalid, araddr, arlen out; arready in).
- axi_rvalid/rready/rlast/rdata: R channel (rready out; rvalid, rlast, rdata in).

Behaviour:
- Reset value of every output is 0; the state machine enters IDLE. Reset takes effect mid-run on the next edge: all valids and readies drop, counters clear.
- Configuration capture:
  - start is accepted only in IDLE with init_end = 1.
  - On acceptance, latch mode, begin_addr and words = (end_addr - begin_addr)/ADDR_STEP.
  - Clear err_cnt, pass and first_err_addr.
- If end_addr <= begin_addr: go directly to FIN; done pulses 2 cycles after start with pass = 1 and no AXI traffic.
- States: IDLE -> AW -> W -> B -> (AW if write words remain, else AR) -> R -> (AR if read words remain, else FIN) -> IDLE.
- Burst length and address:
  - Burst length = min(BURST_LEN, remaining words); awlen/arlen = length - 1.
  - Address advances by length*ADDR_STEP per burst. No 4 KB or row-boundary splitting; `ddr2_ctrl` handles rows.
- AW/AR: valid and payload are held stable until the ready handshake; the handshake moves to W/R the next cycle.
- W channel:
  - wvalid is high throughout W.
  - wdata/wlast advance only on wvalid & wready.
  - wlast is high exactly on beat length-1.
  - W -> B occurs on the handshake of the wlast beat.
- B: bready = 1 in B; bvalid moves to the next state. The response field is not present.
- R channel:
  - rready = 1 in R.
  - On each rvalid & rready, compare rdata with the expected word. On mismatch, err_cnt increments (saturating) and first_err_addr is captured if err_cnt was 0.
  - An rlast early or missing on the expected final beat counts as one error. The burst ends on the expected beat count.
- Pattern generators: separate write and read generators, both reset to the same seed at run start, so read expectation = write sequence.
  - Mode 0: beat index k.
  - Mode 1: 32-bit Galois LFSR (taps 32,22,2,1), replicated/truncated to DATA_WIDTH, stepped per beat.
  - Mode 2: 1 << (k mod DATA_WIDTH).
  - Mode 3: beat address zero-extended/truncated.
- FIN: done = 1 for one cycle, pass = (err_cnt == 0), busy drops the same cycle.
- busy = 1 from the cycle after start acceptance through FIN. start while busy is ignored.
- No outstanding transactions: exactly one burst in flight at a time.

Optional Feature:
- Macro TRAFFIC_CHK_LOOP_EN.
- Defined:
  - Adds input `loop` (1) and output `iter_cnt` (16).
  - When loop = 1 at FIN, the block restarts the write phase without returning to IDLE.
  - The LFSR seed for each iteration = previous final LFSR state; iter_cnt increments per completed pass (saturating).
  - err_cnt accumulates across iterations; done pulses every iteration.
  - Deasserting loop ends the run at the next FIN.
- Not defined: no extra ports; single pass per start.

Test Plan:
- Mode 0, begin 0, end 2048, BURST_LEN 128, ideal slave -> 8 write bursts and 8 read bursts, awlen = arlen = 127, done pulse, pass = 1, err_cnt = 0.
- Mode 1, begin 0, end 300 (150 words) -> bursts of 128 then 22 beats (awlen 127, 21), awaddr 0 then 256; pass = 1.
- Slave corrupts the read beat at address 0x40 (bit 0 flipped), mode 3 -> err_cnt = 1, first_err_addr = 0x40, pass = 0.
- Random wready/rvalid/awready stalls (50%) -> payload stable while valid and not ready; pass = 1, beat counts exact.
- end_addr = begin_addr = 0x100 -> no AXI valids, done pulses, pass = 1. start with init_end = 0 -> busy stays 0.
- rst asserted mid-W burst -> next edge all outputs 0 and IDLE; a subsequent start completes with pass = 1.
